// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types and constants for the LED breathing sequencer.
//   state_t      : brightness FSM states
//   MODE_*       : encodings of the 2-bit mode request
//                  (value 3 is reserved and behaves as MODE_BREATHE)
// ---------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_BREATHE = 2'd1;
  localparam logic [1:0] MODE_CHASE   = 2'd2;

endpackage

// File: rtl/led_breath_seq_if.sv
// ---------------------------------------------------------------------------
// led_breath_seq_if
// Bundle between the board-control registers and the LED sequencer.
//   en, mode   : control side -> sequencer
//   led_out    : PWM LED drive (registered)
//   level      : current brightness level
//   busy       : sequencer is not IDLE
//   cycle_done : one-clock pulse at the end of each complete breath cycle
//   state      : FSM state, exported for observation
//
// Request semantics: there is no valid/ready pair. en and mode are plain
// levels sampled every clock by the sequencer; the control side may change
// them at any time and the sequencer decides when to act on them (mode is
// only captured on entry to RISE, en is acted on at the decision points of
// the FSM).
//
// Modports: master = control-register side, slave = sequencer.
// ---------------------------------------------------------------------------
interface led_breath_seq_if #(
  parameter int NUM_LED  = 8,
  parameter int PWM_BITS = 8
);
  import led_pkg::*;

  logic                en;
  logic [1:0]          mode;
  logic [NUM_LED-1:0]  led_out;
  logic [PWM_BITS-1:0] level;
  logic                busy;
  logic                cycle_done;
  state_t              state;

  modport master (
    output en, mode,
    input  led_out, level, busy, cycle_done, state
  );

  modport slave (
    input  en, mode,
    output led_out, level, busy, cycle_done, state
  );

endinterface

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen
// Step-tick prescaler. Counts 0..TICK_DIV-1 while run is high and holds at 0
// while run is low, so the first tick arrives TICK_DIV clocks after run rises.
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   run   : count enable; low clears the count
//   tick  : one-clock pulse while the count sits at TICK_DIV-1
// ---------------------------------------------------------------------------
module led_tick_gen #(
  parameter int TICK_DIV = 6250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/led_breath_seq.sv
// ---------------------------------------------------------------------------
// led_breath_seq
// LED brightness sequencer: a prescaled step tick drives a brightness FSM
// (RISE / HOLD_HI / FALL / HOLD_LO) that ramps an unsigned level between 0
// and MAX. The level is turned into PWM and driven on all LEDs together
// (BREATHE) or on one LED that moves on after every complete cycle (CHASE).
//   clk   : system clock
//   rst_n : synchronous reset, active low; aborts any cycle immediately
//   bus   : slave side of led_breath_seq_if (en, mode in; led_out, level,
//           busy, cycle_done, state out)
// ---------------------------------------------------------------------------
module led_breath_seq
  import led_pkg::*;
#(
  parameter int NUM_LED    = 8,
  parameter int PWM_BITS   = 8,
  parameter int TICK_DIV   = 6250000,
  parameter int HOLD_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  led_breath_seq_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = MAX - 1'b1;
  localparam int                  PTR_W    = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(NUM_LED - 1);
  localparam int                  HOLD_W   = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  state_t              r_state;
  logic [PWM_BITS-1:0] r_level;
  logic [HOLD_W-1:0]   r_hold;
  logic [PTR_W-1:0]    r_ptr;
  logic [1:0]          r_mode_q;
  logic                r_cycle_done;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [NUM_LED-1:0]  r_led_out;

  state_t              w_state_nxt;
  logic [PWM_BITS-1:0] w_level_nxt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                w_cycle_end;
  logic                w_mode_load;
  logic                w_tick;
  logic                w_run;
  logic                w_run_req;
  logic                w_pwm;
  logic [NUM_LED-1:0]  w_led_nxt;

  // mode=0 counts as "stop" wherever the FSM decides whether to carry on,
  // but only a low en aborts RISE/HOLD_HI.
  assign w_run_req = bus.en && (bus.mode != MODE_OFF);
  assign w_run     = (r_state != IDLE);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .tick  (w_tick)
  );

  // State register plus the datapath registers it steers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_level      <= '0;
      r_hold       <= '0;
      r_ptr        <= '0;
      r_mode_q     <= MODE_OFF;
      r_cycle_done <= 1'b0;
      r_pwm_cnt    <= '0;
      r_led_out    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_level      <= w_level_nxt;
      r_hold       <= w_hold_nxt;
      r_cycle_done <= w_cycle_end;
      r_led_out    <= w_led_nxt;
      if (w_mode_load) begin
        r_mode_q <= bus.mode;
      end
      if (w_cycle_end) begin
        r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
      end
      // Period of MAX clocks so that level==MAX compares true every clock.
      r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
    end
  end

  // Next-state and next-datapath logic. The MAX/0 checks come before the
  // +/-1 so the level can never wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_hold_nxt  = r_hold;
    w_cycle_end = 1'b0;
    w_mode_load = 1'b0;
    case (r_state)
      IDLE: begin
        w_level_nxt = '0;
        w_hold_nxt  = '0;
        if (w_run_req) begin
          w_state_nxt = RISE;
          w_mode_load = 1'b1;
        end
      end
      RISE: begin
        if (!bus.en) begin
          w_state_nxt = FALL;
          w_hold_nxt  = '0;
        end else if (w_tick) begin
          if (r_level == MAX) begin
            w_state_nxt = HOLD_HI;
            w_hold_nxt  = '0;
          end else begin
            w_level_nxt = r_level + 1'b1;
          end
        end
      end
      HOLD_HI: begin
        if (!bus.en) begin
          w_state_nxt = FALL;
          w_hold_nxt  = '0;
        end else if (w_tick) begin
          if (r_hold == HOLD_LAST) begin
            w_state_nxt = FALL;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
      end
      FALL: begin
        if (w_tick) begin
          if (r_level == '0) begin
            w_hold_nxt  = '0;
            w_state_nxt = w_run_req ? HOLD_LO : IDLE;
          end else begin
            w_level_nxt = r_level - 1'b1;
          end
        end
      end
      HOLD_LO: begin
        if (w_tick) begin
          if (r_hold == HOLD_LAST) begin
            w_cycle_end = 1'b1;
            w_hold_nxt  = '0;
            if (w_run_req) begin
              w_state_nxt = RISE;
              w_mode_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: PWM compare and LED pattern, registered into r_led_out.
  always_comb begin
    w_pwm     = (r_pwm_cnt < r_level);
    w_led_nxt = '0;
    if (r_state != IDLE) begin
      if (r_mode_q == MODE_CHASE) begin
        w_led_nxt[r_ptr] = w_pwm;
      end else begin
        w_led_nxt = {NUM_LED{w_pwm}};
      end
    end
  end

  assign bus.led_out    = r_led_out;
  assign bus.level      = r_level;
  assign bus.busy       = (r_state != IDLE);
  assign bus.cycle_done = r_cycle_done;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_led_breath_seq.sv
// ---------------------------------------------------------------------------
// tb_led_breath_seq
// Directed bench for led_breath_seq with NUM_LED=4, PWM_BITS=3 (MAX=7),
// TICK_DIV=4, HOLD_STEPS=2, giving an 80-clock breath cycle.
// Edge numbering: E0 is the edge on which the FSM leaves IDLE; values are
// sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_led_breath_seq;
  import led_pkg::*;

  localparam int NUM_LED    = 4;
  localparam int PWM_BITS   = 3;
  localparam int TICK_DIV   = 4;
  localparam int HOLD_STEPS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_breath_seq_if #(.NUM_LED(NUM_LED), .PWM_BITS(PWM_BITS)) bus ();

  led_breath_seq #(
    .NUM_LED    (NUM_LED),
    .PWM_BITS   (PWM_BITS),
    .TICK_DIV   (TICK_DIV),
    .HOLD_STEPS (HOLD_STEPS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] exp_q[$];   // expected cycle_done edge indices
  int last_cd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cd_seen(input int j);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL cycle_done_unexpected: pulse at edge %0d, none expected", j);
    end else begin
      chk("cycle_done_time", j, 32'(exp_q.pop_front()));
    end
    if (last_cd > 0) chk("cycle_done_spacing", j - last_cd, 80);
    last_cd = j;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived breath waveform: level after edge Ej, position p in cycle.
  // RISE steps every 4 clk up to 7 at p=28, holds through HOLD_HI to p=40,
  // falls to 0 at p=68, stays 0 through HOLD_LO.
  function automatic int lvl_at(input int j);
    int p;
    p = j % 80;
    if (p <= 28) return p / 4;
    if (p <= 40) return 7;
    if (p <= 68) return 7 - (p - 40) / 4;
    return 0;
  endfunction

  // Fade-out after en drops at E22 while level=5.
  function automatic int fade_at(input int j);
    if (j < 24) return 5;
    if (j < 44) return 4 - (j - 24) / 4;
    return 0;
  endfunction

  // Steps from edge j0 to j1 of a running sequence and checks every clock.
  // PWM counter value before Ej is (j+pwm_off)%7; led_out after Ej reflects
  // the level and ptr before Ej.
  task automatic run_check(input int j0, input int j1, input int pwm_off, input bit chase);
    int pb;
    int ptr;
    logic [3:0] le;
    for (int j = j0; j <= j1; j++) begin
      step();
      pb  = (j + pwm_off) % 7;
      ptr = ((j - 1) / 80) % 4;
      le  = (pb < lvl_at(j - 1)) ? (chase ? 4'(1 << ptr) : 4'hF) : 4'h0;
      chk("level", bus.level, lvl_at(j));
      chk("busy", bus.busy, 1);
      chk("led_out", bus.led_out, le);
      if (bus.cycle_done) cd_seen(j);
    end
  endtask

  // Reset for two clocks with en=1, then release into RISE (E0).
  task automatic reset_start(input logic [1:0] m);
    rst_n = 1'b0; bus.en = 1'b1; bus.mode = m;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_level", bus.level, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_led_out", bus.led_out, 0);
      chk("rst_cycle_done", bus.cycle_done, 0);
    end
    rst_n = 1'b1;
    step();
    chk("start_busy", bus.busy, 1);
    chk("start_state", bus.state, RISE);
    chk("start_level", bus.level, 0);
    last_cd = 0;
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       busy;
    logic [2:0] level;
    logic [3:0] led;
    logic       cd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fj;
    logic [3:0] le;

    rst_n = 1'b0; bus.en = 1'b0; bus.mode = 2'd0;

    // Reset with en=1/mode=1, then mode=0 and en=0 must stay idle, then
    // reserved mode 3 starts a breathe-all run.
    vecs[0] = '{1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 4'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 4'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 2'd1, 1'b0, 3'd0, 4'h0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 1'b0, 3'd0, 4'h0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'd1, 1'b0, 3'd0, 4'h0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 2'd3, 1'b1, 3'd0, 4'h0, 1'b0};

    for (int i = 0; i < 6; i++) begin
      rst_n = vecs[i].rst_n; bus.en = vecs[i].en; bus.mode = vecs[i].mode;
      step();
      chk("vec_busy", bus.busy, vecs[i].busy);
      chk("vec_level", bus.level, vecs[i].level);
      chk("vec_led_out", bus.led_out, vecs[i].led);
      chk("vec_cycle_done", bus.cycle_done, vecs[i].cd);
    end

    // Breathe (mode 3 latched): two full cycles; pwm counter is 2 ahead
    // because of the two idle clocks before E0.
    last_cd = 0;
    exp_q.delete();
    exp_q.push_back(16'd80);
    exp_q.push_back(16'd160);
    run_check(1, 160, 2, 1'b0);
    chk("breathe_cd_count", exp_q.size(), 0);

    // Chase over five cycles: active LED 0,1,2,3,0.
    reset_start(2'd2);
    for (int k = 1; k <= 5; k++) exp_q.push_back(16'(80 * k));
    run_check(1, 400, 0, 1'b1);
    chk("chase_cd_count", exp_q.size(), 0);

    // Fade-out: drop en at level 5 in RISE.
    reset_start(2'd1);
    run_check(1, 21, 0, 1'b0);
    bus.en = 1'b0;
    step();
    chk("fade_state", bus.state, FALL);
    chk("fade_level_kept", bus.level, 5);
    for (int j = 23; j <= 60; j++) begin
      step();
      le = ((j % 7) < fade_at(j - 1)) ? 4'hF : 4'h0;
      chk("fade_level", bus.level, fade_at(j));
      chk("fade_busy", bus.busy, (j < 44) ? 1 : 0);
      chk("fade_led_out", bus.led_out, le);
      if (bus.cycle_done) cd_seen(j);
    end
    chk("fade_end_state", bus.state, IDLE);

    // Mid-op reset during HOLD_HI of the second chase cycle (ptr=1).
    reset_start(2'd2);
    exp_q.push_back(16'd80);
    run_check(1, 114, 0, 1'b1);
    chk("midop_state", bus.state, HOLD_HI);
    rst_n = 1'b0;
    step();
    chk("midop_level", bus.level, 0);
    chk("midop_busy", bus.busy, 0);
    chk("midop_led_out", bus.led_out, 0);
    chk("midop_cycle_done", bus.cycle_done, 0);
    chk("midop_state_idle", bus.state, IDLE);
    rst_n = 1'b1;
    step();
    chk("restart_busy", bus.busy, 1);
    chk("restart_level", bus.level, 0);
    last_cd = 0;
    exp_q.delete();
    exp_q.push_back(16'd80);
    run_check(1, 100, 0, 1'b1);   // LED 0 active again => ptr was cleared
    chk("restart_cd_count", exp_q.size(), 0);

    fj = n_err;
    $display("Result: errors=%0d of %0d checks", fj, n_checks);
    $finish;
  end

endmodule
